up_bus_arbiter: RTL and testbench

- Two-master arbiter sharing the single up_* register bus (up_wr/up_rd/up_addr/up_data_wr/up_data_rd/up_wait) between the virtual-JTAG CPU BFM (m0) and an on-chip register sequencer (m1), e.g. a stats poller.
- One transaction at a time: grants a master, forwards its command to the slave side, holds it until the slave drops up_wait, then returns read data and releases the master.
- Sits between the masters and the tester register decode.

---
 rtl/up_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_up_bus_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_bus_arbiter.sv
// Two-master arbiter for the shared up_* register bus (CPU BFM on m0, register sequencer on m1).
// Define UP_ARB_TIMEOUT_EN to abort slave accesses that hold up_wait for TIMEOUT_CYC cycles.
module up_bus_arbiter #(
  parameter int unsigned ARB_MODE     = 0,
  parameter int unsigned TIMEOUT_CYC  = 1024,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic        up_clk,
  input  logic        up_rst_n,
  input  logic        m0_wr,
  input  logic        m0_rd,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_data_wr,
  output logic [31:0] m0_data_rd,
  output logic        m0_wait,
  input  logic        m1_wr,
  input  logic        m1_rd,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_data_wr,
  output logic [31:0] m1_data_rd,
  output logic        m1_wait,
  output logic        up_wr,
  output logic        up_rd,
  output logic [31:0] up_addr,
  output logic [31:0] up_data_wr,
  input  logic [31:0] up_data_rd,
  input  logic        up_wait,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout_flag,
  output logic        timeout_pulse
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state;
  logic   last_grant;
  logic   req0, req1, pick1;

  assign req0 = m0_wr | m0_rd;
  assign req1 = m1_wr | m1_rd;

  // m1 wins only when alone, or on a round-robin tie after m0 was served last
  assign pick1 = req1 & (~req0 | ((ARB_MODE == 0) & ~last_grant));

  assign m0_wait = req0 & ~((state == DONE) & grant[0]);
  assign m1_wait = req1 & ~((state == DONE) & grant[1]);
  assign busy    = (state == ACCESS) | (state == DONE);

`ifdef UP_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] to_cnt;
`else
  logic unused_cfg;
  assign unused_cfg    = ^{TIMEOUT_DATA, 32'(TIMEOUT_CYC)};
  assign timeout_flag  = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  always_ff @(posedge up_clk) begin
    if (!up_rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 2'b00;
      up_wr      <= 1'b0;
      up_rd      <= 1'b0;
      up_addr    <= '0;
      up_data_wr <= '0;
      m0_data_rd <= '0;
      m1_data_rd <= '0;
`ifdef UP_ARB_TIMEOUT_EN
      to_cnt        <= '0;
      timeout_flag  <= 1'b0;
      timeout_pulse <= 1'b0;
`endif
    end else begin
`ifdef UP_ARB_TIMEOUT_EN
      timeout_pulse <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            grant      <= pick1 ? 2'b10 : 2'b01;
            up_addr    <= pick1 ? m1_addr : m0_addr;
            up_data_wr <= pick1 ? m1_data_wr : m0_data_wr;
            // wr takes precedence when a master raises both strobes
            up_wr      <= pick1 ? m1_wr : m0_wr;
            up_rd      <= pick1 ? (m1_rd & ~m1_wr) : (m0_rd & ~m0_wr);
            state      <= ACCESS;
`ifdef UP_ARB_TIMEOUT_EN
            to_cnt     <= '0;
`endif
          end
        end
        ACCESS: begin
          if (!up_wait) begin
            if (up_rd) begin
              if (grant[1]) m1_data_rd <= up_data_rd;
              else          m0_data_rd <= up_data_rd;
            end
            up_wr <= 1'b0;
            up_rd <= 1'b0;
            state <= DONE;
          end
`ifdef UP_ARB_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            if (up_rd) begin
              if (grant[1]) m1_data_rd <= TIMEOUT_DATA;
              else          m0_data_rd <= TIMEOUT_DATA;
            end
            up_wr         <= 1'b0;
            up_rd         <= 1'b0;
            timeout_pulse <= 1'b1;
            timeout_flag  <= 1'b1;
            state         <= DONE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
        DONE: begin
          last_grant <= grant[1];
          grant      <= 2'b00;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_up_bus_arbiter.sv
// Scoreboard bench for up_bus_arbiter: round-robin instance with a wait-state slave model,
// plus a fixed-priority instance for the tie-break check.
module tb_up_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m_wr [2];
  logic        m_rd [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];
  logic        m_wait [2];
  logic        up_wr, up_rd, up_wait;
  logic [31:0] up_addr, up_data_wr, up_data_rd;
  logic [1:0]  grant;
  logic        busy, timeout_flag, timeout_pulse;

  up_bus_arbiter #(.ARB_MODE(0), .TIMEOUT_CYC(8), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
    .up_clk(clk), .up_rst_n(rst_n),
    .m0_wr(m_wr[0]), .m0_rd(m_rd[0]), .m0_addr(m_addr[0]), .m0_data_wr(m_wdata[0]),
    .m0_data_rd(m_rdata[0]), .m0_wait(m_wait[0]),
    .m1_wr(m_wr[1]), .m1_rd(m_rd[1]), .m1_addr(m_addr[1]), .m1_data_wr(m_wdata[1]),
    .m1_data_rd(m_rdata[1]), .m1_wait(m_wait[1]),
    .up_wr(up_wr), .up_rd(up_rd), .up_addr(up_addr), .up_data_wr(up_data_wr),
    .up_data_rd(up_data_rd), .up_wait(up_wait),
    .grant(grant), .busy(busy), .timeout_flag(timeout_flag), .timeout_pulse(timeout_pulse)
  );

  logic        f_wr [2];
  logic        f_rd [2];
  logic [31:0] f_addr [2];
  logic [31:0] f_wdata [2];
  logic [31:0] f_rdata [2];
  logic        f_wait [2];
  logic        f_up_wr, f_up_rd, f_busy, f_tflag, f_tpulse;
  logic [31:0] f_up_addr, f_up_data_wr;
  logic [1:0]  f_grant;
  logic        f_up_wait = 1'b0;
  logic [31:0] f_up_data_rd = 32'h5555_0000;

  up_bus_arbiter #(.ARB_MODE(1)) dut_fp (
    .up_clk(clk), .up_rst_n(rst_n),
    .m0_wr(f_wr[0]), .m0_rd(f_rd[0]), .m0_addr(f_addr[0]), .m0_data_wr(f_wdata[0]),
    .m0_data_rd(f_rdata[0]), .m0_wait(f_wait[0]),
    .m1_wr(f_wr[1]), .m1_rd(f_rd[1]), .m1_addr(f_addr[1]), .m1_data_wr(f_wdata[1]),
    .m1_data_rd(f_rdata[1]), .m1_wait(f_wait[1]),
    .up_wr(f_up_wr), .up_rd(f_up_rd), .up_addr(f_up_addr), .up_data_wr(f_up_data_wr),
    .up_data_rd(f_up_data_rd), .up_wait(f_up_wait),
    .grant(f_grant), .busy(f_busy), .timeout_flag(f_tflag), .timeout_pulse(f_tpulse)
  );

  // Slave model: fixed read table, slave_waits wait states per access, or stuck forever.
  int slave_waits = 0;
  int wait_left = 0;
  bit stuck = 1'b0;

  always_comb begin
    up_wait = stuck | ((up_wr | up_rd) && (wait_left > 0));
    case (up_addr)
      32'h10:  up_data_rd = 32'h1234_5678;
      32'h14:  up_data_rd = 32'h0000_1111;
      32'h18:  up_data_rd = 32'h2222_3333;
      32'h1C:  up_data_rd = 32'h4444_5555;
      default: up_data_rd = 32'hCAFE_0000;
    endcase
  end

  always @(posedge clk) begin
    if (!(up_wr | up_rd)) wait_left <= slave_waits;
    else if (wait_left > 0) wait_left <= wait_left - 1;
  end

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;
  int rd_hi = 0, wr_hi = 0, pulse_n = 0, unstable = 0;
  logic [1:0] act_grant = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic        prev_act = 1'b0;
    logic [31:0] prev_addr = '0, prev_wd = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (up_rd) rd_hi++;
      if (up_wr) wr_hi++;
      if (timeout_pulse) pulse_n++;
      if (up_rd | up_wr) act_grant = grant;
      if ((up_rd | up_wr) && prev_act && (up_addr != prev_addr || up_data_wr != prev_wd)) unstable++;
      prev_act  = up_rd | up_wr;
      prev_addr = up_addr;
      prev_wd   = up_data_wr;
      for (int i = 0; i < 2; i++) begin
        if ((m_wr[i] | m_rd[i]) && !m_wait[i]) begin
          if (sb_q.size() == 0) begin
            chk("sb_unexpected_completion", i, 32'hFFFF_FFFF);
          end else begin
            e = sb_q.pop_front();
            chk("sb_master", i, e.idx);
            chk("sb_rdata", m_rdata[i], e.data);
          end
        end
      end
    end
  endtask

  // Issue one command, hold it until wait drops, release it at the following edge.
  task automatic do_txn(input int idx, input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat);
    m_wr[idx] = wr; m_rd[idx] = rd; m_addr[idx] = addr; m_wdata[idx] = wdata;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (!m_wait[idx]) break;
      if (lat > 200) begin
        chk("txn_timeout", 32'(lat), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    m_wr[idx] = 1'b0; m_rd[idx] = 1'b0;
  endtask

  task automatic sync_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int lat, lat_a0, lat_a1, lat_b0, lat_b1;
  int rd0, wr0, un0, p0, g0, g1, m1done;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_wr[i] = 0; m_rd[i] = 0; m_addr[i] = '0; m_wdata[i] = '0;
      f_wr[i] = 0; f_rd[i] = 0; f_addr[i] = '0; f_wdata[i] = '0;
    end
    fork
      monitor();
      begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_up_rd", up_rd, 1'b0);
    chk("rst_up_wr", up_wr, 1'b0);
    chk("rst_up_addr", up_addr, 32'h0);
    chk("rst_m0_data_rd", m_rdata[0], 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m0_wait_idle", m_wait[0], 1'b0);
    chk("rst_timeout_flag", timeout_flag, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single zero-wait read on m0
    rd0 = rd_hi;
    sb_q.push_back('{0, 32'h1234_5678});
    do_txn(0, 0, 1, 32'h10, 32'h0, lat);
    chk("read_latency", lat, 3);
    chk("read_up_rd_cycles", rd_hi - rd0, 1);
    chk("read_grant", act_grant, 2'b01);
    chk("read_grant_after", grant, 2'b00);

    // Write on m1 with four wait states
    slave_waits = 4;
    rd0 = rd_hi; wr0 = wr_hi; un0 = unstable;
    sb_q.push_back('{1, 32'h0});
    do_txn(1, 1, 0, 32'h20, 32'hA5A5_A5A5, lat);
    chk("write_latency", lat, 7);
    chk("write_up_wr_cycles", wr_hi - wr0, 5);
    chk("write_up_rd_cycles", rd_hi - rd0, 0);
    chk("write_stable", unstable - un0, 0);
    chk("write_grant", act_grant, 2'b10);

    // rd+wr together on m1 issues a write
    slave_waits = 0;
    rd0 = rd_hi; wr0 = wr_hi;
    sb_q.push_back('{1, 32'h0});
    do_txn(1, 1, 1, 32'h30, 32'h0F0F_0F0F, lat);
    chk("rdwr_up_wr_cycles", wr_hi - wr0, 1);
    chk("rdwr_up_rd_cycles", rd_hi - rd0, 0);

    // Round-robin contention from reset: m0, m1, m0, m1
    sync_reset();
    sb_q.push_back('{0, 32'h1234_5678});
    sb_q.push_back('{1, 32'h0000_1111});
    sb_q.push_back('{0, 32'h2222_3333});
    sb_q.push_back('{1, 32'h4444_5555});
    fork
      begin
        do_txn(0, 0, 1, 32'h10, 32'h0, lat_a0);
        do_txn(0, 0, 1, 32'h18, 32'h0, lat_b0);
      end
      begin
        do_txn(1, 0, 1, 32'h14, 32'h0, lat_a1);
        do_txn(1, 0, 1, 32'h1C, 32'h0, lat_b1);
      end
    join
    chk("rr_lat_m0_first", lat_a0, 3);
    chk("rr_lat_m1_first", lat_a1, 6);
    chk("rr_lat_m0_second", lat_b0, 6);
    chk("rr_lat_m1_second", lat_b1, 6);

    // Reset during the second wait cycle of an access
    slave_waits = 10;
    m_rd[0] = 1; m_addr[0] = 32'h10;
    @(posedge clk);
    @(posedge clk); #1;
    chk("midrst_up_rd_before", up_rd, 1'b1);
    rst_n = 1'b0; m_rd[0] = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_up_rd", up_rd, 1'b0);
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_m0_data_rd", m_rdata[0], 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    slave_waits = 0;
    sb_q.push_back('{0, 32'h2222_3333});
    do_txn(0, 0, 1, 32'h18, 32'h0, lat);
    chk("midrst_fresh_latency", lat, 3);

    // Fixed priority: m0 wins every tie
    f_rd[0] = 1; f_rd[1] = 1; f_addr[0] = 32'h4; f_addr[1] = 32'h8;
    g0 = 0; g1 = 0; m1done = 0;
    repeat (20) begin
      @(negedge clk);
      if (f_grant == 2'b01) g0++;
      if (f_grant == 2'b10) g1++;
      if (!f_wait[1]) m1done++;
    end
    chk("fp_m0_grant_cycles", g0, 13);
    chk("fp_m1_grant_cycles", g1, 0);
    chk("fp_m1_served", m1done, 0);
    chk("fp_m0_data_rd", f_rdata[0], 32'h5555_0000);
    @(posedge clk); #1 f_rd[0] = 0; f_rd[1] = 0;

    // Slave that never releases up_wait
`ifdef UP_ARB_TIMEOUT_EN
    rd0 = rd_hi; p0 = pulse_n;
    stuck = 1'b1;
    sb_q.push_back('{0, 32'hDEAD_BEEF});
    do_txn(0, 0, 1, 32'h10, 32'h0, lat);
    stuck = 1'b0;
    chk("to_latency", lat, 10);
    chk("to_up_rd_cycles", rd_hi - rd0, 8);
    repeat (3) @(negedge clk);
    chk("to_pulse_count", pulse_n - p0, 1);
    chk("to_flag_sticky", timeout_flag, 1'b1);
`else
    stuck = 1'b1;
    m_rd[0] = 1; m_addr[0] = 32'h10;
    repeat (20) @(negedge clk);
    chk("stuck_m0_wait", m_wait[0], 1'b1);
    chk("stuck_busy", busy, 1'b1);
    chk("stuck_no_flag", timeout_flag, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0; m_rd[0] = 0; stuck = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
`endif

    repeat (3) @(posedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
